// File: rtl/fetch_pkg.sv
// Shared types and constants for the TinyChip fetch stage.
// No logic here; imported by instr_fetch and branch_lut.
package fetch_pkg;

  localparam int PC_W_DEF      = 10;
  localparam int INSTR_W_DEF   = 9;
  localparam int LUT_DEPTH_DEF = 32;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch-target register file: synchronous write, asynchronous read, synchronous clear.
// Read data follows raddr in the same cycle; writes land on the next rising edge.
module branch_lut import fetch_pkg::*; #(
  parameter int DEPTH  = LUT_DEPTH_DEF,
  parameter int DATA_W = PC_W_DEF,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] entries [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (we) begin
      entries[waddr] <= wdata;
    end
  end

  assign rdata = entries[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, registers one instruction per cycle for the decoder, one-edge latency.
// stall freezes all fetch state; a taken branch overrides stall and costs one invalid bubble.
module instr_fetch import fetch_pkg::*; #(
  parameter int PC_W      = PC_W_DEF,
  parameter int INSTR_W   = INSTR_W_DEF,
  parameter int LUT_DEPTH = LUT_DEPTH_DEF,
  parameter int LUT_IDX_W = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [LUT_IDX_W-1:0] target_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [INSTR_W-1:0]   instruct,
  output logic                 instr_valid,
  output logic [PC_W-1:0]      instr_pc,
  output logic                 done
);

  fetch_state_t         state;
  logic [PC_W-1:0]      pc;
  logic [PC_W-1:0]      branch_target;
  logic                 is_halt;

  branch_lut #(
    .DEPTH  (LUT_DEPTH),
    .DATA_W (PC_W),
    .IDX_W  (LUT_IDX_W)
  ) u_branch_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we && (state == IDLE)),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (target_idx),
    .rdata (branch_target)
  );

  assign imem_addr = pc;
  assign is_halt   = (imem_data == INSTR_W'(HALT_INSTR));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruct    <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= '0;
          end
        end
        RUN: begin
          if (branch_taken) begin
            pc          <= branch_target;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instruct    <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            // The halt word itself is delivered as valid; pc stays on it.
            if (is_halt) state <= HALT;
            else         pc    <= pc + PC_W'(1);
          end
        end
        HALT: begin
          // done lags the state by one edge so the halt word is seen with done low.
          instr_valid <= 1'b0;
          if (start) begin
            state <= RUN;
            pc    <= '0;
            done  <= 1'b0;
          end else begin
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an expected-output scoreboard.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, stall, branch_taken, lut_we;
  logic [4:0] target_idx, lut_waddr;
  logic [9:0] lut_wdata, imem_addr, instr_pc;
  logic [8:0] imem_data, instruct;
  logic       instr_valid, done;

  logic [8:0] mem [0:1023];

  typedef struct packed {
    logic [8:0] instr;
    logic [9:0] ipc;
    logic       v;
    logic       d;
    logic [9:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  instr_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .target_idx   (target_idx),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instruct     (instruct),
    .instr_valid  (instr_valid),
    .instr_pc     (instr_pc),
    .done         (done)
  );

  function automatic logic [8:0] f(input int a);
    return 9'((a + 1) & 'hFF);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic stl, input logic br, input logic [4:0] idx);
    start        = st;
    stall        = stl;
    branch_taken = br;
    target_idx   = idx;
    lut_we       = 1'b0;
  endtask

  task automatic expect_out(input logic [8:0] instr, input logic [9:0] ipc,
                            input logic v, input logic d, input logic [9:0] pc);
    exp_t e;
    e.instr = instr; e.ipc = ipc; e.v = v; e.d = d; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check("instruct",    16'(instruct),    16'(e.instr));
      check("instr_pc",    16'(instr_pc),    16'(e.ipc));
      check("instr_valid", 16'(instr_valid), 16'(e.v));
      check("done",        16'(done),        16'(e.d));
      check("pc",          16'(imem_addr),   16'(e.pc));
    end
  endtask

  task automatic lut_write(input logic [4:0] idx, input logic [9:0] data);
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    lut_we    = 1'b1;
    lut_waddr = idx;
    lut_wdata = data;
    expect_out(9'h0, 10'h0, 1'b0, 1'b0, 10'h0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = f(i);
    mem[7] = HALT_INSTR;
    reset = 1'b1; lut_waddr = '0; lut_wdata = '0;
    drive(1'b0, 1'b0, 1'b0, 5'd0);

    // Reset state
    expect_out(9'h0, 10'h0, 1'b0, 1'b0, 10'h0); tick();
    expect_out(9'h0, 10'h0, 1'b0, 1'b0, 10'h0); tick();
    reset = 1'b0;

    // IDLE ignores stall/branch; preload LUT
    drive(1'b0, 1'b1, 1'b1, 5'd3);
    expect_out(9'h0, 10'h0, 1'b0, 1'b0, 10'h0); tick();
    lut_write(5'd3, 10'h040);
    lut_write(5'd4, 10'h005);
    lut_write(5'd5, 10'h3FF);
    lut_write(5'd6, 10'h100);

    // Start and sequential fetch
    drive(1'b1, 1'b0, 1'b0, 5'd0);
    expect_out(9'h0, 10'h0, 1'b0, 1'b0, 10'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    for (int a = 0; a < 5; a++) begin
      expect_out(f(a), 10'(a), 1'b1, 1'b0, 10'(a + 1)); tick();
    end

    // Branch at pc=5 to lut[3]=0x040: one bubble
    drive(1'b0, 1'b0, 1'b1, 5'd3);
    expect_out(f(4), 10'h4, 1'b0, 1'b0, 10'h040); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    expect_out(f(10'h040), 10'h040, 1'b1, 1'b0, 10'h041); tick();

    // Stall three cycles
    drive(1'b0, 1'b1, 1'b0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      expect_out(f(10'h040), 10'h040, 1'b1, 1'b0, 10'h041); tick();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    expect_out(f(10'h041), 10'h041, 1'b1, 1'b0, 10'h042); tick();

    // Branch wins over stall
    drive(1'b0, 1'b1, 1'b1, 5'd6);
    expect_out(f(10'h041), 10'h041, 1'b0, 1'b0, 10'h100); tick();

    // start and lut_we ignored in RUN
    drive(1'b1, 1'b0, 1'b0, 5'd0);
    lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'h200;
    expect_out(f(10'h100), 10'h100, 1'b1, 1'b0, 10'h101); tick();

    // Reach pc=7 (halt word) and branch away from it
    drive(1'b0, 1'b0, 1'b1, 5'd4);
    expect_out(f(10'h100), 10'h100, 1'b0, 1'b0, 10'h005); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    expect_out(f(5), 10'h5, 1'b1, 1'b0, 10'h6); tick();
    expect_out(f(6), 10'h6, 1'b1, 1'b0, 10'h7); tick();
    drive(1'b0, 1'b0, 1'b1, 5'd3);
    expect_out(f(6), 10'h6, 1'b0, 1'b0, 10'h040); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    expect_out(f(10'h040), 10'h040, 1'b1, 1'b0, 10'h041); tick();

    // PC wrap from 0x3FF
    drive(1'b0, 1'b0, 1'b1, 5'd5);
    expect_out(f(10'h040), 10'h040, 1'b0, 1'b0, 10'h3FF); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    expect_out(f(10'h3FF), 10'h3FF, 1'b1, 1'b0, 10'h000); tick();
    expect_out(f(0), 10'h0, 1'b1, 1'b0, 10'h001); tick();

    // Halt at address 4
    mem[4] = HALT_INSTR;
    for (int a = 1; a < 4; a++) begin
      expect_out(f(a), 10'(a), 1'b1, 1'b0, 10'(a + 1)); tick();
    end
    expect_out(HALT_INSTR, 10'h4, 1'b1, 1'b0, 10'h4); tick();
    drive(1'b0, 1'b1, 1'b1, 5'd3);
    expect_out(HALT_INSTR, 10'h4, 1'b0, 1'b1, 10'h4); tick();
    expect_out(HALT_INSTR, 10'h4, 1'b0, 1'b1, 10'h4); tick();

    // Restart from HALT
    drive(1'b1, 1'b0, 1'b0, 5'd0);
    expect_out(HALT_INSTR, 10'h4, 1'b0, 1'b0, 10'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    expect_out(f(0), 10'h0, 1'b1, 1'b0, 10'h1); tick();
    expect_out(f(1), 10'h1, 1'b1, 1'b0, 10'h2); tick();

    // Reset mid-RUN clears outputs and LUT
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 5'd3);
    expect_out(9'h0, 10'h0, 1'b0, 1'b0, 10'h0); tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 5'd0);
    expect_out(9'h0, 10'h0, 1'b0, 1'b0, 10'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    expect_out(f(0), 10'h0, 1'b1, 1'b0, 10'h1); tick();
    expect_out(f(1), 10'h1, 1'b1, 1'b0, 10'h2); tick();
    drive(1'b0, 1'b0, 1'b1, 5'd3);
    expect_out(f(1), 10'h1, 1'b0, 1'b0, 10'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0);
    expect_out(f(0), 10'h0, 1'b1, 1'b0, 10'h1); tick();

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the TinyChip core. It owns the program counter and presents one 9-bit instruction per cycle, registered, to the control decoder directly downstream. It also resolves taken branches through a 32-entry branch-target lookup table and halts on the reserved halt encoding.

## Interface
Parameters:
- PC_W, 10, program-counter and instruction-memory address width
- INSTR_W, 9, instruction width; must equal the decoder input width
- LUT_DEPTH, 32, number of branch-target entries; the index width is log2(LUT_DEPTH)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  launches program execution from PC 0; honoured in IDLE and HALT only
- stall  in  1  downstream back-pressure; freezes the fetch state
- branch_taken  in  1  redirect request from execute
- target_idx  in  5  branch LUT index, sampled when branch_taken=1
- lut_we  in  1  LUT write enable; honoured in IDLE only
- lut_waddr  in  5  LUT write index
- lut_wdata  in  PC_W  LUT write data
- imem_addr  out  PC_W  instruction memory address; combinationally equal to pc
- imem_data  in  INSTR_W  instruction memory read data; asynchronous read of imem_addr
- instruct  out  INSTR_W  registered instruction presented to the decoder
- instr_valid  out  1  instruct is a real, non-flushed instruction
- instr_pc  out  PC_W  PC of the instruction in instruct
- done  out  1  high while in HALT

## Operation
- States: IDLE, RUN, HALT. The state type lives in fetch_pkg.
- Reset clears: state=IDLE, pc=0, instruct=0, instr_valid=0, instr_pc=0, done=0, and all LUT entries to 0.
- IDLE:
  - start=1 moves to RUN with pc=0.
  - lut_we writes lut[lut_waddr] = lut_wdata.
  - Other inputs are ignored.
- RUN, priority order per cycle:
  1. branch_taken=1 (wins over stall and halt):
     - pc <= lut[target_idx]
     - instr_valid <= 0, flushing the wrong-path instruction
     - instruct and instr_pc hold
  2. stall=1: pc, instruct, instr_valid and instr_pc all hold.
  3. Normal fetch:
     - instruct <= imem_data
     - instr_pc <= pc
     - instr_valid <= 1
     - pc <= pc+1, wrapping modulo 2^PC_W (max to 0, no flag)
  4. If the normal fetch captures HALT_INSTR (9'h1FF): the halt is latched as a valid instruction, the state moves to HALT, and pc holds.
- HALT:
  - done=1.
  - instr_valid <= 0 on the first HALT cycle and stays 0.
  - pc, instruct and instr_pc hold.
  - branch_taken and stall are ignored.
  - start=1 returns to RUN with pc=0 and done=0. The LUT is retained.
- start in RUN is ignored. lut_we outside IDLE is ignored; the LUT is unchanged.
- reset asserted mid-RUN or mid-HALT takes effect at the next edge, overriding all other inputs.

## Timing
- All outputs are registered except imem_addr.
- Fetch latency: imem_data at pc appears on instruct one edge later.
- Start sequence:
  - start sampled at edge E0 → state=RUN, pc=0.
  - Edge E1 → instruct=mem[0], instr_valid=1, pc=1.
- Redirect penalty is one bubble:
  - branch_taken at edge Eb → pc=target, instr_valid=0.
  - Edge Eb+1 → instruct=mem[target], instr_valid=1.
- Stall has zero-cycle effect: outputs are unchanged at the edge where stall=1 is sampled.
- done rises at the edge that latches HALT_INSTR + 1, i.e. the edge entering HALT's first cycle.

## Structure
- fetch_pkg contains:
  - fetch_state_t enum {IDLE, RUN, HALT}
  - HALT_INSTR = 9'h1FF
  - default PC_W, INSTR_W, LUT_DEPTH
- Sub-module branch_lut:
  - LUT_DEPTH x PC_W register file
  - synchronous write, asynchronous read, synchronous reset to 0
- instr_fetch holds the FSM, the PC, and the instruct/instr_valid/instr_pc registers.
- The instruction memory is external; it is not instantiated here.

## Test plan
- Reset, then start; memory holds 9'h001, 9'h002, 9'h003 at 0..2.
  - Required: instruct = 001, 002, 003 on consecutive cycles after E1.
  - Required: instr_pc = 0, 1, 2; instr_valid=1.
- In IDLE write lut[3]=10'h040; in RUN assert branch_taken with target_idx=3 while pc=5.
  - Required: one cycle with instr_valid=0.
  - Required: then instruct=mem[0x040], instr_pc=0x040.
- Hold stall=1 for 3 cycles mid-run.
  - Required: instruct, instr_pc and pc frozen; fetch resumes with pc+1 afterwards.
  - Also assert branch_taken together with stall. Required: the redirect is taken.
- Place 9'h1FF at address 4.
  - Required: instruct=1FF with instr_valid=1, then done=1 and instr_valid=0.
  - Required: pc holds and branch_taken is ignored.
  - Then pulse start. Required: restart from pc 0, done=0.
- Halt encoding on the wrong path: 9'h1FF at address 7, with branch_taken asserted while pc=7.
  - Required: no HALT; the redirect is taken.
- PC wrap and reset mid-operation:
  - Preload a LUT entry to 10'h3FF and redirect to it. Required: after the fetch at 0x3FF, pc=0.
  - Assert reset mid-RUN. Required: all outputs return to reset values and the LUT is cleared.
